// File: rtl/hash_pkg.sv
// Hash/nonce widths, the queued share record and the core-to-comparison bit-order helper.
package hash_pkg;

    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;

    typedef struct packed {
        logic [HASH_W-1:0]  hash;
        logic [NONCE_W-1:0] nonce;
    } share_t;

    // The hash core emits its result LSB-first; difficulty compares need it MSB-first.
    function automatic logic [HASH_W-1:0] bit_reverse(input logic [HASH_W-1:0] h);
        logic [HASH_W-1:0] r;
        for (int b = 0; b < HASH_W; b++) begin
            r[HASH_W-1-b] = h[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/share_fifo.sv
// First-word-fall-through queue of share_t records with a valid/ready pop side.
module share_fifo
    import hash_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    input  share_t push_data,
    output logic   push_accept,
    output logic   pop_valid,
    input  logic   pop_ready,
    output share_t pop_data
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates the full case from the empty case.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    share_t      mem [DEPTH];
    logic        full;
    logic        pop;

    assign pop_valid   = (wr_ptr != rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = pop_valid && pop_ready;
    assign push_accept = push_valid && (!full || pop);
    assign pop_data    = pop_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)         rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/share_filter.sv
// Detects new hash results, keeps those below target and queues them; the drop counter
// exists only when SHARE_FILTER_DROP_CNT_EN is defined.
module share_filter
    import hash_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               enable,
    input  logic [HASH_W-1:0]  hash_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic [HASH_W-1:0]  target_i,
    output logic               share_valid_o,
    input  logic               share_ready_i,
    output logic [HASH_W-1:0]  share_hash_o,
    output logic [NONCE_W-1:0] share_nonce_o,
    output logic [31:0]        share_count_o,
    output logic [15:0]        drop_count_o
);

    share_t             cur;
    share_t             prev;
    logic               armed;
    logic               cand;
    logic               s1_flag;
    share_t             s1_share;
    logic [HASH_W-1:0]  s1_rev;
    logic [HASH_W-1:0]  s1_target;
    logic               s2_push;
    share_t             s2_share;
    logic               push_accept;
    share_t             head;

    assign cur  = {hash_i, nonce_i};
    assign cand = enable && armed && (cur != prev);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            prev    <= '0;
            armed   <= 1'b0;
            s1_flag <= 1'b0;
            s2_push <= 1'b0;
        end else begin
            prev    <= cur;
            armed   <= 1'b1;
            s1_flag <= cand;
            s2_push <= s1_flag && (s1_rev < s1_target);
        end
    end

    // Payload stages are only consumed when their flag is set, so they carry no reset.
    always_ff @(posedge clk) begin
        s1_share  <= cur;
        s1_rev    <= bit_reverse(hash_i);
        s1_target <= target_i;
        s2_share  <= s1_share;
    end

    share_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst_i),
        .push_valid  (s2_push),
        .push_data   (s2_share),
        .push_accept (push_accept),
        .pop_valid   (share_valid_o),
        .pop_ready   (share_ready_i),
        .pop_data    (head)
    );

    assign share_hash_o  = head.hash;
    assign share_nonce_o = head.nonce;

    always_ff @(posedge clk) begin
        if (rst_i)            share_count_o <= '0;
        else if (push_accept) share_count_o <= share_count_o + 32'd1;
    end

`ifdef SHARE_FILTER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_i)
            drop_count_o <= '0;
        else if (s2_push && !push_accept && (drop_count_o != 16'hFFFF))
            drop_count_o <= drop_count_o + 16'd1;
    end
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_share_filter.sv
// Randomised and directed bench for share_filter with a queue-based reference model and scoreboard.
module tb_share_filter;

    localparam int DEPTH = 4;
`ifdef SHARE_FILTER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct { logic [255:0] h; logic [31:0] n; } sh_t;
    typedef struct { logic v; logic [255:0] h; logic [31:0] n; } att_t;

    logic         clk = 1'b0;
    logic         rst_i, enable, share_ready_i, share_valid_o;
    logic [255:0] hash_i, target_i, share_hash_o;
    logic [31:0]  nonce_i, share_nonce_o, share_count_o;
    logic [15:0]  drop_count_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    share_filter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .enable        (enable),
        .hash_i        (hash_i),
        .nonce_i       (nonce_i),
        .target_i      (target_i),
        .share_valid_o (share_valid_o),
        .share_ready_i (share_ready_i),
        .share_hash_o  (share_hash_o),
        .share_nonce_o (share_nonce_o),
        .share_count_o (share_count_o),
        .drop_count_o  (drop_count_o)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a share is any fresh result whose MSB-first value is below target;
    // it reaches the queue two edges after being sampled, and a full queue drops it unless
    // the head leaves on the same edge.
    sh_t         mq[$];
    sh_t         exp_q[$];
    att_t        pend[$];
    logic [255:0] m_prev_h;
    logic [31:0]  m_prev_n;
    bit           m_armed;
    int unsigned  m_cnt;
    int unsigned  m_drop;

    always @(posedge clk) begin : model
        att_t a;
        bit pop, ok;
        logic [255:0] rev;
        if (rst_i) begin
            mq.delete(); exp_q.delete(); pend.delete();
            m_prev_h = '0; m_prev_n = '0; m_armed = 1'b0;
            m_cnt = 0; m_drop = 0;
        end else begin
            pop = (mq.size() > 0) && share_ready_i;
            if (pop) void'(mq.pop_front());
            if (pend.size() == 2) begin
                a = pend.pop_front();
                if (a.v) begin
                    ok = (mq.size() < DEPTH);
                    if (ok) begin
                        mq.push_back('{a.h, a.n});
                        exp_q.push_back('{a.h, a.n});
                        m_cnt++;
                    end else if (m_drop < 32'hFFFF) begin
                        m_drop++;
                    end
                end
            end
            rev = {<<{hash_i}};
            a.v = enable && m_armed && ({hash_i, nonce_i} != {m_prev_h, m_prev_n}) && (rev < target_i);
            a.h = hash_i;
            a.n = nonce_i;
            pend.push_back(a);
            m_prev_h = hash_i;
            m_prev_n = nonce_i;
            m_armed  = 1'b1;
        end
    end

    // Monitor: per-cycle status against the model, payload against the scoreboard on each pop.
    always @(negedge clk) begin : monitor
        sh_t e;
        check("valid", share_valid_o, mq.size() > 0);
        check("share_count", share_count_o, m_cnt);
        check("drop_count", drop_count_o, DROP_EN ? m_drop : 0);
        if (!rst_i && share_valid_o && share_ready_i) begin
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_hash", share_hash_o, e.h);
                check("sb_nonce", share_nonce_o, e.n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [255:0] h, input logic [31:0] n);
        hash_i  = h;
        nonce_i = n;
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Low 16 core bits clear means the top 16 compare bits are clear: below 2^240.
    function automatic logic [255:0] pass_hash();
        logic [255:0] r;
        r = rand_hash();
        r[15:0] = '0;
        return r;
    endfunction

    initial begin : driver
        logic [255:0] ones;
        logic [255:0] t240;
        logic [255:0] one_h;
        ones  = '1;
        t240  = '0; t240[240] = 1'b1;
        rst_i = 1'b1; enable = 1'b1; share_ready_i = 1'b0;
        hash_i = ones; nonce_i = '0; target_i = t240;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_valid", share_valid_o, 0);
        check("rst_hash", share_hash_o, 0);
        check("rst_nonce", share_nonce_o, 0);
        check("rst_count", share_count_o, 0);
        check("rst_drop", drop_count_o, 0);

        // Steady all-ones input never qualifies.
        repeat (8) tick();
        check("steady_valid", share_valid_o, 0);
        check("steady_count", share_count_o, 0);

        // Reversed value 1 against 2^240: share visible three cycles later.
        one_h = '0; one_h[255] = 1'b1;
        drive(one_h, 32'h2A); tick();
        drive(ones, 0); tick();
        check("no_bypass_valid", share_valid_o, 0);
        tick();
        check("lat_valid", share_valid_o, 1);
        check("lat_nonce", share_nonce_o, 32'h2A);
        check("lat_hash", share_hash_o, one_h);
        check("lat_count", share_count_o, 1);
        share_ready_i = 1'b1; tick(); share_ready_i = 1'b0;
        check("pop_empty", share_valid_o, 0);

        // Reversed value exactly equal to target is not a share.
        one_h = '0; one_h[15] = 1'b1;
        drive(one_h, 32'h2B); tick();
        drive(ones, 0); tick(); tick(); tick();
        check("eq_valid", share_valid_o, 0);
        check("eq_count", share_count_o, 1);

        // Six back-to-back shares into a 4-deep queue with no consumer.
        for (int i = 0; i < 6; i++) begin
            drive(pass_hash(), 32'h100 + i);
            tick();
        end
        drive(ones, 0);
        repeat (4) tick();
        check("full_count", share_count_o, 5);
        check("full_drop", drop_count_o, DROP_EN ? 2 : 0);
        check("full_head", share_nonce_o, 32'h100);

        // Full queue: pop and push on the same edge both happen.
        drive(pass_hash(), 32'h200); tick();
        drive(ones, 0); tick();
        share_ready_i = 1'b1; tick(); share_ready_i = 1'b0;
        check("pp_count", share_count_o, 6);
        check("pp_drop", drop_count_o, DROP_EN ? 2 : 0);
        check("pp_valid", share_valid_o, 1);
        check("pp_head", share_nonce_o, 32'h101);
        share_ready_i = 1'b1; repeat (6) tick(); share_ready_i = 1'b0;
        check("drain_valid", share_valid_o, 0);

        // Reset with two queued and one in flight.
        drive(pass_hash(), 32'h300); tick();
        drive(pass_hash(), 32'h301); tick();
        drive(ones, 0); tick();
        drive(pass_hash(), 32'h302); tick();
        drive(ones, 0);
        check("pre_rst_count", share_count_o, 8);
        check("pre_rst_head", share_nonce_o, 32'h300);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("mid_rst_valid", share_valid_o, 0);
        check("mid_rst_count", share_count_o, 0);
        check("mid_rst_drop", drop_count_o, 0);
        check("mid_rst_hash", share_hash_o, 0);
        repeat (6) tick();
        check("inflight_gone", share_valid_o, 0);
        check("inflight_count", share_count_o, 0);

        // Random traffic against the model.
        repeat (600) begin
            enable        = ($urandom_range(0, 7) != 0);
            share_ready_i = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: ;
                1: drive(pass_hash(), $urandom);
                2: drive(rand_hash(), $urandom);
                default: drive(ones, $urandom_range(0, 3));
            endcase
            target_i = ($urandom_range(0, 5) == 0) ? rand_hash() : t240;
            rst_i    = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i = 1'b0; enable = 1'b0; share_ready_i = 1'b1;
        repeat (12) tick();
        check("end_valid", share_valid_o, 0);
        check("end_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/share_filter.md
SHARE_FILTER -- requirements
Module: share_filter

Interface
REQ-001 SHALL have port clk, input, 1: single clock, rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port enable, input, 1: candidate detection enable.
REQ-004 SHALL have port hash_i, input, 256: best hash from the upstream hash core (core bit order).
REQ-005 SHALL have port nonce_i, input, 32: nonce paired with hash_i.
REQ-006 SHALL have port target_i, input, 256: share target, comparison bit order (MSB = most significant).
REQ-007 SHALL have port share_valid_o, output, 1: FIFO head valid.
REQ-008 SHALL have port share_ready_i, input, 1: consumer ready; pop when valid & ready.
REQ-009 SHALL have port share_hash_o, output, 256: head hash, core bit order.
REQ-010 SHALL have port share_nonce_o, output, 32: head nonce.
REQ-011 SHALL have port share_count_o, output, 32: shares accepted into FIFO, wrapping.
REQ-012 SHALL have port drop_count_o, output, 16: shares lost to full FIFO, saturating.
REQ-013 SHALL have parameter FIFO_DEPTH, default 4: entries, power of two, minimum 2.

Function
REQ-014 SHALL register {hash_i, nonce_i} every cycle as prev, regardless of enable.
REQ-015 SHALL flag a candidate in cycle N when all hold: enable=1, armed=1, and {hash_i, nonce_i} != prev. armed is 0 after reset and is set 1 on the first non-reset edge.
REQ-016 Stage 1 (edge N+1) SHALL capture the candidate flag, hash_i, nonce_i, target_i, and the bit-reverse of hash_i (rev[255-b] = hash_i[b]).
REQ-017 Stage 2 (edge N+2) SHALL push {hash, nonce} into the FIFO iff flag=1 and rev < target_i, as an unsigned 256-bit compare.
REQ-018 Latency: a share seen at cycle N with the FIFO empty SHALL show share_valid_o=1 in cycle N+3.
REQ-019 Back-to-back candidates on consecutive cycles SHALL each be evaluated; the pipeline SHALL not stall.
REQ-020 The FIFO SHALL be first-word-fall-through; outputs SHALL be stable while valid=1 and ready=0.
REQ-021 With the FIFO full, a push with no simultaneous pop SHALL be discarded, drop_count_o SHALL increment, and share_count_o SHALL not change.
REQ-022 With the FIFO full, a push and pop in the same cycle SHALL both take effect; the share SHALL be accepted.
REQ-023 With the FIFO empty, a push SHALL not bypass to the outputs in the same cycle (REQ-018 governs).
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.
REQ-025 share_count_o SHALL increment per accepted push and wrap from 0xFFFFFFFF to 0; drop_count_o SHALL saturate at 0xFFFF.
REQ-026 When enable=0, no new candidates SHALL be detected, in-flight stages SHALL complete, and the output handshake SHALL continue.

Reset
REQ-027 On rst_i=1 at an edge, the block SHALL clear: FIFO pointers, stage flags, armed, counters, share_valid_o=0, share_hash_o=0, share_nonce_o=0, prev=0.
REQ-028 Reset mid-operation SHALL discard in-flight candidates and FIFO contents with no partial pop, and share_valid_o SHALL be 0 in the following cycle.

Configuration
REQ-029 Macro SHARE_FILTER_DROP_CNT_EN, when defined, SHALL implement drop_count_o per REQ-021/025.
REQ-030 When SHARE_FILTER_DROP_CNT_EN is undefined, drop_count_o SHALL be constant 0, no drop-counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package hash_pkg SHALL hold HASH_W=256, NONCE_W=32, the typedef share_t {hash, nonce}, and a bit-reverse function.
REQ-032 The FIFO SHALL be a sub-module share_fifo (parameterised share_t storage with valid/ready pop); share_filter SHALL hold detection, compare and counters.

Verification
REQ-033 Bench SHALL check: reset, then hash_i=all-ones and nonce 0 held steady -> share_valid_o stays 0 and share_count_o=0.
REQ-034 Bench SHALL check: target_i=2^240, with at cycle N a hash whose reversed value is 0x00..01 and nonce=0x2A -> cycle N+3 share_valid_o=1, share_nonce_o=0x2A, share_count_o=1.
REQ-035 Bench SHALL check: same as REQ-034 but reversed hash=2^240 exactly -> no push, since equality is not a share.
REQ-036 Bench SHALL check: share_ready_i=0, 6 consecutive passing candidates, DEPTH=4 -> 4 entries in order, drop_count_o=2 (0 without the macro), share_count_o=4.
REQ-037 Bench SHALL check: FIFO full, ready=1 and a passing candidate arriving together -> accepted, drop_count_o unchanged, order preserved.
REQ-038 Bench SHALL check: rst_i pulsed while 2 entries are queued and 1 is in flight -> next cycle share_valid_o=0, counters 0, and the in-flight share never appears.
